// File: rtl/micro_ucr_hash_pkg.sv
// micro_ucr_hash_pkg: constants, round function and verifier states shared by the miner and the verifier
package micro_ucr_hash_pkg;
  localparam logic [23:0] H_INICIAL = {8'h01, 8'h89, 8'hFE};
  localparam logic [7:0] K_A = 8'h99;
  localparam logic [7:0] K_B = 8'hA1;
  localparam logic [4:0] RONDA_CAMBIO = 5'd16;
  typedef enum logic [1:0] {ESPERA, RONDAS, COMPARA, ENTREGA} estado_t;
  // h = {H0, H1, H2}; returns the state after round i consuming byte w
  function automatic logic [23:0] ronda(input logic [23:0] h, input logic [7:0] w, input logic [4:0] i);
    logic [7:0] k, x, a;
    k = (i <= RONDA_CAMBIO) ? K_A : K_B;
    x = (i <= RONDA_CAMBIO) ? h[15:8] ^ h[7:0] : h[23:16] ^ h[15:8];
    a = x + k + w;
    return {h[15:8] ^ h[7:0], h[3:0], h[7:4], h[23:16] + a};
  endfunction
endpackage

// File: rtl/micro_ucr_hash_ronda.sv
// micro_ucr_hash_ronda: one combinational hash round plus the next step of the 16-byte W window
module micro_ucr_hash_ronda
  import micro_ucr_hash_pkg::*;
(
  input  logic [23:0]      h,
  input  logic [15:0][7:0] w,
  input  logic [4:0]       i,
  output logic [23:0]      h_sig,
  output logic [15:0][7:0] w_sig
);
  // w[0] holds W[i]; the appended byte is W[i+16] = W[i+13] | (W[i+7] ^ W[i+2])
  assign h_sig = ronda(h, w[0], i);
  assign w_sig = {w[13] | (w[7] ^ w[2]), w[15:1]};
endmodule

// File: rtl/verificador_bounty.sv
// verificador_bounty: recomputes the micro UCR hash one round per cycle and checks the miner's claim and target
module verificador_bounty
  import micro_ucr_hash_pkg::*;
#(
  parameter int NUM_RONDAS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sol_valida,
  output logic        sol_lista,
  input  logic [95:0] bloque_datos,
  input  logic [31:0] nonce,
  input  logic [23:0] hash_reportado,
  input  logic [7:0]  target,
  output logic        res_valido,
  input  logic        res_acepta,
  output logic [23:0] hash_calculado,
  output logic        hash_coincide,
  output logic        cumple_target
);
  localparam logic [4:0] ULTIMA = 5'(NUM_RONDAS - 1);
  estado_t estado;
  logic [15:0][7:0] w, w_ini, w_sig;
  logic [23:0] h, h_sig, hash_ref;
  logic [7:0] target_q;
  logic [4:0] cnt;
  // byte 0 of the block is the most significant; it must land in w[0]
  assign w_ini = {<<8{bloque_datos, nonce}};
  assign sol_lista = estado == ESPERA;
  micro_ucr_hash_ronda u_ronda (
    .h    (h),
    .w    (w),
    .i    (cnt),
    .h_sig(h_sig),
    .w_sig(w_sig)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= ESPERA;
      w <= '0;
      h <= '0;
      cnt <= '0;
      hash_ref <= '0;
      target_q <= '0;
      res_valido <= 1'b0;
      hash_calculado <= '0;
      hash_coincide <= 1'b0;
      cumple_target <= 1'b0;
    end else begin
      case (estado)
        ESPERA: if (sol_valida) begin
          w <= w_ini;
          h <= H_INICIAL;
          cnt <= '0;
          hash_ref <= hash_reportado;
          target_q <= target;
          estado <= RONDAS;
        end
        RONDAS: begin
          w <= w_sig;
          h <= h_sig;
          cnt <= cnt + 5'd1;
          if (cnt == ULTIMA) estado <= COMPARA;
        end
        COMPARA: begin
          hash_calculado <= h;
          hash_coincide <= h == hash_ref;
          cumple_target <= (h[23:16] < target_q) && (h[15:8] < target_q);
          res_valido <= 1'b1;
          estado <= ENTREGA;
        end
        ENTREGA: if (res_acepta) begin
          res_valido <= 1'b0;
          estado <= ESPERA;
        end
        default: estado <= ESPERA;
      endcase
    end
  end
endmodule

// File: tb/tb_verificador_bounty.sv
// tb_verificador_bounty: randomized scoreboard bench against a full-array golden model of the micro UCR hash
module tb_verificador_bounty;
  logic clk = 1'b0, reset = 1'b1, sol_valida = 1'b0, res_acepta = 1'b1;
  logic sol_lista, res_valido, hash_coincide, cumple_target;
  logic [95:0] bloque_datos = '0;
  logic [31:0] nonce = '0;
  logic [23:0] hash_reportado = '0, hash_calculado;
  logic [7:0] target = '0;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [23:0] hash;
    logic coincide;
    logic cumple;
    int t;
  } esp_t;
  esp_t sb[$];
  esp_t e;
  bit seen = 0;

  verificador_bounty dut (
    .clk(clk), .reset(reset), .sol_valida(sol_valida), .sol_lista(sol_lista),
    .bloque_datos(bloque_datos), .nonce(nonce), .hash_reportado(hash_reportado),
    .target(target), .res_valido(res_valido), .res_acepta(res_acepta),
    .hash_calculado(hash_calculado), .hash_coincide(hash_coincide),
    .cumple_target(cumple_target)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] golden(input logic [95:0] b, input logic [31:0] n);
    logic [7:0] wv[32];
    logic [7:0] h0, h1, h2, k, x, a;
    for (int i = 0; i < 12; i++) wv[i] = b[95-8*i -: 8];
    for (int i = 0; i < 4; i++) wv[12+i] = n[31-8*i -: 8];
    for (int i = 16; i < 32; i++) wv[i] = wv[i-3] | (wv[i-9] ^ wv[i-14]);
    h0 = 8'h01; h1 = 8'h89; h2 = 8'hFE;
    for (int i = 0; i < 32; i++) begin
      k = (i <= 16) ? 8'h99 : 8'hA1;
      x = (i <= 16) ? (h1 ^ h2) : (h0 ^ h1);
      a = x + k + wv[i];
      {h0, h1, h2} = {h1 ^ h2, h2[3:0], h2[7:4], h0 + a};
    end
    return {h0, h1, h2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: one pop per presented result
  always @(negedge clk) begin
    if (reset || !res_valido) seen = 0;
    else if (!seen) begin
      seen = 1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got hash %0h with no request pending", hash_calculado);
      end else begin
        e = sb.pop_front();
        chk("hash_calculado", 32'(hash_calculado), 32'(e.hash));
        chk("hash_coincide", 32'(hash_coincide), 32'(e.coincide));
        chk("cumple_target", 32'(cumple_target), 32'(e.cumple));
        chk("latency", cyc - e.t, 33);
      end
    end
  end

  task automatic send(input logic [95:0] b, input logic [31:0] n, input logic [23:0] hr,
                      input logic [7:0] tg, output int waited);
    logic [23:0] g;
    g = golden(b, n);
    @(negedge clk);
    bloque_datos = b; nonce = n; hash_reportado = hr; target = tg; sol_valida = 1'b1;
    waited = 0;
    while (!sol_lista && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!sol_lista) begin
      errors++;
      $display("FAIL send_timeout: sol_lista stayed 0 for %0d cycles", waited);
    end else sb.push_back('{g, g == hr, (g[23:16] < tg) && (g[15:8] < tg), cyc + 1});
    @(posedge clk);
    #1;
    sol_valida = 1'b0;
    bloque_datos = {$urandom, $urandom, $urandom};
    nonce = $urandom;
    hash_reportado = 24'($urandom);
    target = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || res_valido) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_done: result still pending after %0d cycles", n);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valido && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", 32'(res_valido), 1);
  endtask

  initial begin
    logic [95:0] b;
    logic [31:0] n;
    logic [23:0] g, g0, held;
    logic [7:0] mx;
    int w;
    #2;
    chk("reset_sol_lista", 32'(sol_lista), 1);
    chk("reset_res_valido", 32'(res_valido), 0);
    chk("reset_hash", 32'(hash_calculado), 0);
    chk("reset_coincide", 32'(hash_coincide), 0);
    chk("reset_cumple", 32'(cumple_target), 0);
    @(negedge clk);
    reset = 1'b0;
    g0 = golden('0, '0);
    // zero block with the golden hash, then with bit 0 flipped
    send('0, '0, g0, 8'hFF, w);
    wait_done();
    send('0, '0, g0 ^ 24'h1, 8'hFF, w);
    wait_done();
    // target boundaries
    send({$urandom, $urandom, $urandom}, $urandom, 24'($urandom), 8'h00, w);
    wait_done();
    send('0, '0, g0, g0[23:16], w);
    wait_done();
    do begin
      b = {$urandom, $urandom, $urandom};
      n = $urandom;
      g = golden(b, n);
      mx = (g[23:16] > g[15:8]) ? g[23:16] : g[15:8];
    end while (mx == 8'hFF);
    send(b, n, g, mx + 8'd1, w);
    wait_done();
    // held result with busy requester toggling inputs
    res_acepta = 1'b0;
    b = {$urandom, $urandom, $urandom};
    n = $urandom;
    send(b, n, golden(b, n), 8'($urandom), w);
    wait_valid();
    held = hash_calculado;
    sol_valida = 1'b1;
    repeat (10) begin
      bloque_datos = {$urandom, $urandom, $urandom};
      nonce = $urandom;
      @(negedge clk);
      chk("hold_sol_lista", 32'(sol_lista), 0);
      chk("hold_res_valido", 32'(res_valido), 1);
      chk("hold_hash", 32'(hash_calculado), 32'(held));
    end
    res_acepta = 1'b1;
    b = {$urandom, $urandom, $urandom};
    n = $urandom;
    send(b, n, golden(b, n), 8'($urandom), w);
    chk("back_to_back_wait", w, 0);
    wait_done();
    // asynchronous reset while a result is held
    res_acepta = 1'b0;
    send({$urandom, $urandom, $urandom}, $urandom, 24'($urandom), 8'($urandom), w);
    wait_valid();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_res_valido", 32'(res_valido), 0);
    chk("async_rst_sol_lista", 32'(sol_lista), 1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    res_acepta = 1'b1;
    b = {$urandom, $urandom, $urandom};
    n = $urandom;
    send(b, n, golden(b, n), 8'hFF, w);
    wait_done();
    // reset in the middle of the rounds
    send({$urandom, $urandom, $urandom}, $urandom, 24'($urandom), 8'($urandom), w);
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    b = {$urandom, $urandom, $urandom};
    n = $urandom;
    send(b, n, golden(b, n), 8'hFF, w);
    wait_done();
    // random requests
    repeat (20) begin
      b = {$urandom, $urandom, $urandom};
      n = $urandom;
      g = golden(b, n);
      send(b, n, ($urandom_range(0, 1) == 1) ? g : g ^ (24'h1 << $urandom_range(0, 23)),
           8'($urandom), w);
      wait_done();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
